// File: rtl/alu_decode_stage.sv
// RV32I decode stage feeding the integer ALU: one registered bundle slot with
// valid/ready handshake on both sides, full throughput and a flush input.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  alu_op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        use_pc,
  output logic        wr_en,
  output logic        illegal
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 4;
  localparam int unsigned REGW   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [OPW-1:0]  alu_op;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            use_pc;
    logic            wr_en;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       in_xfer;
  logic       valid_q;
  bundle_t    dec_c;
  bundle_t    bundle_q;

  assign opcode  = in_insn[6:0];
  assign funct3  = in_insn[14:12];
  assign funct7  = in_insn[31:25];
  assign in_ready = !flush && (!valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;

  // Instruction decode into the next bundle value.
  always_comb begin
    logic legal;
    logic is_op;
    logic is_store;
    logic is_upper;
    legal    = 1'b0;
    is_op    = (opcode == OPC_OP);
    is_store = (opcode == OPC_STORE);
    is_upper = (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    dec_c    = '0;
    dec_c.pc = in_pc;

    case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_ZERO) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_c.alu_op = {in_insn[30], funct3};
      end
      OPC_OP_IMM: begin
        dec_c.use_imm = 1'b1;
        dec_c.alu_op  = {(funct3 == 3'b101) && in_insn[30], funct3};
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec_c.imm = {27'b0, in_insn[24:20]};
        end else begin
          dec_c.imm = {{20{in_insn[31]}}, in_insn[31:20]};
        end
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_ZERO);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        end else begin
          legal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        legal         = 1'b1;
        dec_c.use_imm = 1'b1;
        dec_c.use_pc  = (opcode == OPC_AUIPC);
        dec_c.imm     = {in_insn[31:12], 12'b0};
      end
      OPC_LOAD: begin
        legal         = 1'b1;
        dec_c.use_imm = 1'b1;
        dec_c.imm     = {{20{in_insn[31]}}, in_insn[31:20]};
      end
      OPC_STORE: begin
        legal         = 1'b1;
        dec_c.use_imm = 1'b1;
        dec_c.imm     = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
      end
      default: legal = 1'b0;
    endcase

    dec_c.rs1   = is_upper ? '0 : in_insn[19:15];
    dec_c.rs2   = (is_op || is_store) ? in_insn[24:20] : '0;
    dec_c.rd    = is_store ? '0 : in_insn[11:7];
    dec_c.wr_en = legal && !is_store && (dec_c.rd != '0);

    // Illegal encodings travel as a neutral bundle with only the flag set.
    if (!legal) begin
      dec_c.illegal = 1'b1;
      dec_c.alu_op  = '0;
      dec_c.imm     = '0;
      dec_c.use_imm = 1'b0;
      dec_c.use_pc  = 1'b0;
    end
  end

  // Pipeline slot: flush wins, then intake, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_xfer) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (in_xfer) begin
        bundle_q <= dec_c;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = bundle_q.pc;
  assign alu_op    = bundle_q.alu_op;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign rd        = bundle_q.rd;
  assign imm       = bundle_q.imm;
  assign use_imm   = bundle_q.use_imm;
  assign use_pc    = bundle_q.use_pc;
  assign wr_en     = bundle_q.wr_en;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed test-plan cases plus randomized traffic
// checked every cycle against a queue-based decode model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        use_imm, use_pc, wr_en, illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        wr_en;
    logic        illegal;
  } bundle_t;

  bundle_t q[$];

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .use_imm(use_imm), .use_pc(use_pc), .wr_en(wr_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode written directly from the instruction-class rules.
  function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
    bundle_t b;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    bit is_op  = (op == 7'h33);
    bit is_opi = (op == 7'h13);
    bit is_lui = (op == 7'h37);
    bit is_aui = (op == 7'h17);
    bit is_ld  = (op == 7'h03);
    bit is_st  = (op == 7'h23);
    bit shift  = is_opi && (f3 == 3'd1 || f3 == 3'd5);
    bit legal;
    logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
    logic [31:0] imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    logic [31:0] imm_u = {i[31:12], 12'h000};
    b = '0;
    b.pc  = pc;
    b.rs1 = (is_lui || is_aui) ? 5'd0 : i[19:15];
    b.rs2 = (is_op || is_st) ? i[24:20] : 5'd0;
    b.rd  = is_st ? 5'd0 : i[11:7];
    if (is_op)       legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (is_opi) legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    else             legal = is_lui || is_aui || is_ld || is_st;
    if (!legal) begin
      b.illegal = 1'b1;
      return b;
    end
    if (is_op)       b.alu_op = {i[30], f3};
    else if (is_opi) b.alu_op = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
    if (is_opi)              b.imm = shift ? 32'(i[24:20]) : imm_i;
    else if (is_lui|is_aui)  b.imm = imm_u;
    else if (is_ld)          b.imm = imm_i;
    else if (is_st)          b.imm = imm_s;
    b.use_imm = !is_op;
    b.use_pc  = is_aui;
    b.wr_en   = !is_st && (b.rd != 5'd0);
    return b;
  endfunction

  function automatic logic [31:0] gen_insn();
    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h33, 7'h13};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    int r = $urandom_range(0, 3);
    if (k < 8) w[6:0] = ops[k];
    if (r == 0) w[31:25] = 7'h00;
    else if (r == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  // Per-cycle scoreboard: the queue holds the bundle the slot must present.
  always @(negedge clk) begin
    bundle_t b_dut;
    logic exp_ready;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_ready = !flush && (q.size() == 0 || out_ready);
      chk("sb.in_ready", 128'(in_ready), 128'(exp_ready));
      chk("sb.out_valid", 128'(out_valid), 128'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        b_dut = '{out_pc, alu_op, rs1, rs2, rd, imm, use_imm, use_pc, wr_en, illegal};
        chk("sb.bundle", 128'(b_dut), 128'(q[0]));
      end
      if (q.size() != 0 && (out_ready || flush)) void'(q.pop_front());
      if (in_valid && exp_ready) q.push_back(model(in_insn, in_pc));
    end
  end

  task automatic send(input logic [31:0] insn, input logic [31:0] pc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_insn = insn; in_pc = pc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bundle_t m;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b1;

    // Pin the model against hand-decoded encodings.
    m = model(32'h40335293, 32'h0);
    chk("model.srai.op", 128'(m.alu_op), 128'(4'b1101));
    chk("model.srai.imm", 128'(m.imm), 128'(32'h3));
    m = model(32'h002081B3, 32'h0);
    chk("model.add.rd", 128'(m.rd), 128'(5'd3));
    m = model(32'hFE112E23, 32'h0);
    chk("model.sw.imm", 128'(m.imm), 128'(32'hFFFFFFFC));
    m = model(32'h80209193, 32'h0);
    chk("model.slli.ill", 128'(m.illegal), 128'(1'b1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst.in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst.out_pc", 128'(out_pc), 128'(32'h0));
    chk("rst.imm", 128'(imm), 128'(32'h0));
    chk("rst.flags", 128'({alu_op, rd, wr_en, illegal}), 128'(0));
    rst_n = 1'b1;

    send(32'h002081B3, 32'h100);
    chk("add.valid", 128'(out_valid), 128'(1'b1));
    chk("add.alu_op", 128'(alu_op), 128'(4'b0000));
    chk("add.regs", 128'({rs1, rs2, rd}), 128'({5'd1, 5'd2, 5'd3}));
    chk("add.use_imm", 128'(use_imm), 128'(1'b0));
    chk("add.wr_en", 128'(wr_en), 128'(1'b1));
    chk("add.out_pc", 128'(out_pc), 128'(32'h100));
    send(32'h402081B3, 32'h104);
    chk("sub.alu_op", 128'(alu_op), 128'(4'b1000));
    send(32'h40335293, 32'h108);
    chk("srai.alu_op", 128'(alu_op), 128'(4'b1101));
    chk("srai.imm", 128'(imm), 128'(32'h3));
    chk("srai.regs", 128'({rs1, rd, use_imm}), 128'({5'd6, 5'd5, 1'b1}));
    send(32'hFFF00093, 32'h10C);
    chk("addi.imm", 128'(imm), 128'(32'hFFFFFFFF));
    chk("addi.alu_op", 128'(alu_op), 128'(4'b0000));
    send(32'h123450B7, 32'h110);
    chk("lui.imm", 128'(imm), 128'(32'h12345000));
    chk("lui.rs1", 128'({rs1, use_imm}), 128'({5'd0, 1'b1}));
    send(32'h00000000, 32'h114);
    chk("zero.ill", 128'({illegal, wr_en, alu_op}), 128'({1'b1, 1'b0, 4'b0000}));
    send(32'h80209193, 32'h118);
    chk("slli.ill", 128'({illegal, wr_en, alu_op}), 128'({1'b1, 1'b0, 4'b0000}));

    // Backpressure: first bundle held, second waits at the input.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'h002081B3; in_pc = 32'h200;
    @(posedge clk); #1;
    in_insn = 32'h402081B3; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp.hold_pc", 128'(out_pc), 128'(32'h200));
      chk("bp.hold_op", 128'(alu_op), 128'(4'b0000));
      chk("bp.in_ready", 128'(in_ready), 128'(1'b0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.second_pc", 128'(out_pc), 128'(32'h204));
    chk("bp.second_op", 128'(alu_op), 128'(4'b1000));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.drained", 128'(out_valid), 128'(1'b0));

    // Flush beats a simultaneous input while a bundle is held.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'h00000013; in_pc = 32'h300;
    @(posedge clk); #1;
    in_insn = 32'h123450B7; in_pc = 32'h304; flush = 1'b1;
    @(negedge clk);
    chk("fl.in_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl.out_valid", 128'(out_valid), 128'(1'b0));
    chk("fl.not_taken", 128'(out_pc), 128'(32'h300));
    out_ready = 1'b1;

    // Asynchronous reset mid-stream.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'h002081B3; in_pc = 32'h400;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 128'(out_valid), 128'(1'b0));
    chk("arst.data", 128'({out_pc, imm, alu_op, rs1, rs2, rd}), 128'(0));
    @(posedge clk); #3;
    rst_n = 1'b1; out_ready = 1'b1;

    // Randomized traffic; the scoreboard checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_insn   = gen_insn();
      in_pc     = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end.empty", 128'(out_valid), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
